// File: rtl/fsm_pkg.sv
// Shared types for the serial "101" transmitter and detector benches.
// Pure declarations: no latency, no backpressure.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } tx_state_t;

  localparam logic [2:0] PATTERN_101 = 3'b101;

endpackage

// File: rtl/bitstream_tx_if.sv
// Load handshake and serial output bundle of bitstream_tx.
// Source (master) holds load_* while load_ready is low; DUT (slave) drives tx_*.
interface bitstream_tx_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              load_valid;
  logic              load_ready;
  logic [WORD_W-1:0] load_data;
  logic [CNT_W-1:0]  load_len;
  logic              tx_bit;
  logic              tx_valid;
  logic              done;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output load_valid, load_data, load_len,
    input  load_ready, tx_bit, tx_valid, done, match_cnt
  );

  modport slave (
    input  load_valid, load_data, load_len,
    output load_ready, tx_bit, tx_valid, done, match_cnt
  );
endinterface

// File: rtl/pattern_match_counter.sv
// Saturating count of overlapping "101" in a valid-qualified bit stream; clear wins.
// Count reflects bits consumed up to the previous edge; never stalls.
module pattern_match_counter
  import fsm_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  logic [1:0]       hist_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      hist_q  <= '0;
      count_q <= '0;
    end else if (valid_i) begin
      hist_q <= {hist_q[0], bit_i};
      if (({hist_q, bit_i} == PATTERN_101) && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bitstream_tx.sv
// MSB-first serial transmitter: bits in T+1..T+N after handshake at T, done at T+N+1,
// load_ready only in IDLE. BITSTREAM_TX_DEBUG_EN adds state_out/remaining_out.
module bitstream_tx
  import fsm_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  bitstream_tx_if.slave    bus_if
`ifdef BITSTREAM_TX_DEBUG_EN
  ,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] remaining_out
`endif
);

  tx_state_t         state_q;
  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  remain_q;
  logic [CNT_W-1:0]  remain_d;
  logic              handshake;

  assign handshake = bus_if.load_valid && (state_q == IDLE);
  assign remain_d  = (bus_if.load_len > CNT_W'(WORD_W)) ? CNT_W'(WORD_W) : bus_if.load_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      remain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            shift_q  <= bus_if.load_data;
            remain_q <= remain_d;
            state_q  <= (remain_d == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          shift_q  <= {shift_q[WORD_W-2:0], 1'b0};
          remain_q <= remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches an output.
  assign bus_if.load_ready = (state_q == IDLE);
  assign bus_if.tx_valid   = (state_q == SHIFT);
  assign bus_if.tx_bit     = (state_q == SHIFT) && shift_q[WORD_W-1];
  assign bus_if.done       = (state_q == DONE);

  pattern_match_counter #(
    .CNT_W (CNT_W)
  ) u_match (
    .clock   (clock),
    .reset   (reset),
    .bit_i   (bus_if.tx_bit),
    .valid_i (bus_if.tx_valid),
    .clear_i (handshake),
    .count_o (bus_if.match_cnt)
  );

`ifdef BITSTREAM_TX_DEBUG_EN
  assign state_out     = state_q;
  assign remaining_out = remain_q;
`endif

endmodule

// File: tb/tb_bitstream_tx.sv
// Self-checking bench for bitstream_tx: cycle-accurate schedule model plus directed literals.
module tb_bitstream_tx;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  bitstream_tx_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

`ifdef BITSTREAM_TX_DEBUG_EN
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_remaining;
`endif

  bitstream_tx #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clock  (clk),
    .reset  (rst),
    .bus_if (bus)
`ifdef BITSTREAM_TX_DEBUG_EN
    ,
    .state_out     (dbg_state),
    .remaining_out (dbg_remaining)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: on acceptance, the whole per-cycle output schedule of the transfer is precomputed.
  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic       b;
    logic       dn;
    logic [3:0] cnt;
  } exp_t;

  exp_t        sched[$];
  exp_t        cur;
  logic [3:0]  last_cnt;
  bit          model_ok = 0;

  task automatic build(input logic [WORD_W-1:0] d, input logic [CNT_W-1:0] l);
    int n;
    int cnt;
    int bits[WORD_W];
    exp_t e;
    n   = (int'(l) > WORD_W) ? WORD_W : int'(l);
    cnt = 0;
    for (int k = 0; k < WORD_W; k++) bits[k] = int'(d[WORD_W-1-k]);
    for (int k = 0; k < n; k++) begin
      e = '{rdy: 1'b0, vld: 1'b1, b: bits[k][0], dn: 1'b0, cnt: 4'(cnt)};
      sched.push_back(e);
      if (k >= 2 && bits[k-2] == 1 && bits[k-1] == 0 && bits[k] == 1 && cnt < 15) cnt++;
    end
    e = '{rdy: 1'b0, vld: 1'b0, b: 1'b0, dn: 1'b1, cnt: 4'(cnt)};
    sched.push_back(e);
    last_cnt = 4'(cnt);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
      last_cnt = '0;
    end else if (sched.size() > 0) begin
      void'(sched.pop_front());
    end else if (bus.load_valid) begin
      build(bus.load_data, bus.load_len);
    end
    if (sched.size() > 0) cur = sched[0];
    else cur = '{rdy: 1'b1, vld: 1'b0, b: 1'b0, dn: 1'b0, cnt: last_cnt};
    model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_load_ready", 32'(bus.load_ready), 32'(cur.rdy));
      chk("m_tx_valid",   32'(bus.tx_valid),   32'(cur.vld));
      chk("m_tx_bit",     32'(bus.tx_bit),     32'(cur.b));
      chk("m_done",       32'(bus.done),       32'(cur.dn));
      chk("m_match_cnt",  32'(bus.match_cnt),  32'(cur.cnt));
    end
  end

  // Offers one word, waits for acceptance, then collects bits until done.
  task automatic send(input logic [7:0] d, input logic [3:0] l,
                      output logic [15:0] bits, output int nb, output int lat,
                      output logic [3:0] cnt);
    int g;
    bits = '0;
    nb   = 0;
    lat  = 0;
    cnt  = '0;
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_len   = l;
    g = 0;
    while (!bus.load_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      timeout_fail("accept");
      bus.load_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (bus.tx_valid) begin
        bits = {bits[14:0], bus.tx_bit};
        nb++;
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) timeout_fail("done_wait");
    cnt = bus.match_cnt;
  endtask

  logic [15:0] r_bits;
  int          r_nb;
  int          r_lat;
  logic [3:0]  r_cnt;

  initial begin
    int t0;
    int t1;
    int g;
    int dn;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_match_cnt",  32'(bus.match_cnt),  32'd0);
    rst = 1'b0;

    send(8'b1011_0101, 4'd8, r_bits, r_nb, r_lat, r_cnt);
    chk("d1_nbits", 32'(r_nb), 32'd8);
    chk("d1_bits", 32'(r_bits[7:0]), 32'b1011_0101);
    chk("d1_latency", 32'(r_lat), 32'd9);
    chk("d1_count", 32'(r_cnt), 32'd3);

    send(8'b1010_0000, 4'd3, r_bits, r_nb, r_lat, r_cnt);
    chk("d2_nbits", 32'(r_nb), 32'd3);
    chk("d2_bits", 32'(r_bits[2:0]), 32'b101);
    chk("d2_latency", 32'(r_lat), 32'd4);
    chk("d2_count", 32'(r_cnt), 32'd1);

    send(8'b1111_1111, 4'd0, r_bits, r_nb, r_lat, r_cnt);
    chk("len0_nbits", 32'(r_nb), 32'd0);
    chk("len0_latency", 32'(r_lat), 32'd1);
    chk("len0_count", 32'(r_cnt), 32'd0);

    send(8'b1010_1010, 4'd12, r_bits, r_nb, r_lat, r_cnt);
    chk("clamp_nbits", 32'(r_nb), 32'd8);
    chk("clamp_bits", 32'(r_bits[7:0]), 32'b1010_1010);
    chk("clamp_latency", 32'(r_lat), 32'd9);
    chk("clamp_count", 32'(r_cnt), 32'd3);

    // Reset while the 4th bit is on the line.
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'b1011_0101;
    bus.load_len   = 4'd8;
    g = 0;
    while (!bus.load_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) timeout_fail("rst_mid_accept");
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_tx_valid",   32'(bus.tx_valid),   32'd0);
    chk("rmid_load_ready", 32'(bus.load_ready), 32'd1);
    chk("rmid_match_cnt",  32'(bus.match_cnt),  32'd0);
    chk("rmid_done",       32'(bus.done),       32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("rmid_no_done", 32'(dn), 32'd0);

    // Reset and load_valid together: nothing captured.
    rst = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    bus.load_len   = 4'd8;
    @(negedge clk);
    rst = 1'b0;
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk("rstvld_tx_valid",   32'(bus.tx_valid),   32'd0);
    chk("rstvld_load_ready", 32'(bus.load_ready), 32'd1);

    // Two words queued back to back with load_valid held high.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'b1101_0110;
    bus.load_len   = 4'd5;
    g = 0;
    while (!bus.load_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) timeout_fail("q_accept1");
    t0 = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.load_data = 8'b0101_1011;
    bus.load_len  = 4'd6;
    g = 0;
    while (!bus.load_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) timeout_fail("q_accept2");
    t1 = cyc;
    chk("queued_gap", 32'(t1 - t0), 32'd7);
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)), r_bits, r_nb, r_lat, r_cnt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
